// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: shares one 8-bit ALU between two requesters (A, B).
// A granted request is latched, its opcode is decoded to a one-hot ALU select
// for 1 or MULTI_LAT cycles, and the result is returned on a valid/ready
// response channel tagged with the requester ID.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (A always wins
// a tie). Leave it undefined for round-robin.

// 3-to-8 one-hot decoder driving the ALU operation select.
module decoder_3X8 (
   input  logic [2:0] in,
   output logic [7:0] out
);

   // Exactly one output bit set for every input code.
   always_comb begin
      out     = '0;
      out[in] = 1'b1;
   end

endmodule

module alu_op_arbiter #(
   parameter logic [7:0]  MULTI_MASK = 8'b0000_0000,
   parameter int unsigned MULTI_LAT  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [2:0] a_op,
   input  logic [7:0] a_x,
   input  logic [7:0] a_y,
   input  logic       b_valid,
   output logic       b_ready,
   input  logic [2:0] b_op,
   input  logic [7:0] b_x,
   input  logic [7:0] b_y,
   output logic [7:0] alu_sel,
   output logic [7:0] alu_x,
   output logic [7:0] alu_y,
   input  logic [7:0] alu_res,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_data,
   output logic       busy
);

   // Counter reload for multi-cycle opcodes; single-cycle opcodes reload 0.
   localparam logic [3:0] MultiCnt = 4'(MULTI_LAT - 1);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] op_q, op_d;
   logic [7:0] x_q, x_d;
   logic [7:0] y_q, y_d;
   logic       id_q, id_d;
   logic [7:0] data_q, data_d;
   logic       last_q, last_d;
   logic       gnt_a, gnt_b;
   logic [2:0] gnt_op;
   logic [7:0] dec_sel;

   decoder_3X8 u_dec (
      .in  (op_q),
      .out (dec_sel)
   );

   // Arbitration between the two valids; last_q names the port that won last.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (a_valid && !b_valid) begin
         gnt_a = 1'b1;
      end else if (!a_valid && b_valid) begin
         gnt_b = 1'b1;
      end else if (a_valid && b_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         gnt_a = 1'b1;
`else
         if (last_q) gnt_a = 1'b1;
         else        gnt_b = 1'b1;
`endif
      end
   end

   assign gnt_op = gnt_b ? b_op : a_op;

   // Next-state and output decode for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      x_d       = x_q;
      y_d       = y_q;
      id_d      = id_q;
      data_d    = data_q;
      last_d    = last_q;
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      alu_sel   = '0;
      alu_x     = '0;
      alu_y     = '0;
      rsp_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            // No grant is advertised on a reset edge: it would be discarded.
            a_ready = gnt_a && !rst;
            b_ready = gnt_b && !rst;
            if (gnt_a || gnt_b) begin
               op_d    = gnt_op;
               x_d     = gnt_b ? b_x : a_x;
               y_d     = gnt_b ? b_y : a_y;
               id_d    = gnt_b;
               cnt_d   = MULTI_MASK[gnt_op] ? MultiCnt : 4'd0;
               state_d = StExec;
            end
         end
         StExec: begin
            alu_sel = dec_sel;
            alu_x   = x_q;
            alu_y   = y_q;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               data_d  = alu_res;
               state_d = StResp;
            end
         end
         StResp: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               last_d  = id_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign rsp_id   = id_q;
   assign rsp_data = data_q;
   assign busy     = (state_q != StIdle);

   // State register with synchronous reset; A wins the first tie after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         id_q    <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         x_q     <= x_d;
         y_q     <= y_d;
         id_q    <= id_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: doc/alu_op_arbiter.md
Name: alu_op_arbiter

Overview:
- Shares the single 8-bit ALU between two requesters (port A, port B) using round-robin arbitration.
- Captures the granted request's 3-bit opcode and operands, then drives the ALU's one-hot operation select through an internal decoder_3X8 instance.
- Holds the operation for its programmed latency, captures the result and returns it on a valid/ready response channel tagged with the requester ID.
- Sits between the instruction/control front-end and the ALU datapath.

Parameters:
- MULTI_MASK, 8'b0000_0000, bit k set means opcode k is multi-cycle.
- MULTI_LAT, 4, EXEC cycles for multi-cycle opcodes; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  port A request valid.
- a_ready  output  1  port A request accepted this cycle.
- a_op  input  3  port A opcode.
- a_x  input  8  port A operand X.
- a_y  input  8  port A operand Y.
- b_valid, b_ready, b_op, b_x, b_y: same directions, widths and meanings for port B.
- alu_sel  output  8  one-hot ALU operation select.
- alu_x  output  8  ALU operand X.
- alu_y  output  8  ALU operand Y.
- alu_res  input  8  ALU result (combinational from alu_sel/alu_x/alu_y).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted by consumer.
- rsp_id  output  1  0 = port A, 1 = port B.
- rsp_data  output  8  captured ALU result.
- busy  output  1  high in EXEC or RESP.

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - State returns to IDLE; any in-flight operation is abandoned and no response is produced.
  - Operand/opcode latches, counter, rsp_data and rsp_id clear to 0.
  - last_grant is set to 1, so A wins the first tie.
  - All outputs are 0: a_ready, b_ready, alu_sel, alu_x, alu_y, rsp_valid, rsp_id, rsp_data, busy.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If only one valid is high, that port is granted.
  - If both are high, the port that is not last_grant is granted.
  - The granted port's ready is asserted combinationally for that cycle only; the other ready stays 0.
  - On the edge, latch op/x/y and the grant ID, load cnt = (MULTI_MASK[op] ? MULTI_LAT : 1) - 1, and go to EXEC.
  - If no valid is high, stay in IDLE with both readies at 0.
- EXEC:
  - alu_sel = decoder_3X8(latched op), exactly one bit set.
  - alu_x and alu_y are driven from the latches.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, capture alu_res into rsp_data on that edge and go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id and rsp_data are held stable until rsp_ready = 1.
  - On the handshake edge: go to IDLE, set last_grant = rsp_id.
  - No grant is issued in the handshake cycle.
- Latency and throughput:
  - Accept-to-rsp_valid is L+1 cycles, where L = EXEC cycles (1 or MULTI_LAT).
  - Minimum issue interval is L+2 cycles.
- Outside EXEC: alu_sel, alu_x and alu_y are forced to 0.
- Request rules:
  - Requesters must hold op/x/y stable while valid is high.
  - Deasserting valid before ready is legal; nothing is captured.
  - A valid that arrives while busy waits; its ready stays 0.
- Back-to-back: a port holding valid continuously while the other also requests alternates grants A, B, A, B.
- MULTI_LAT = 1 behaves identically to a single-cycle op.
- Width: no arithmetic on data; cnt is 4 bits and never underflows.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; A always wins when both valid; last_grant is unused. B can starve; this is intended for debug/bring-up.
- Undefined: round-robin as above. Ports are identical in both builds.

Test Plan:
- Reset mid-EXEC: assert rst for 1 cycle while an op with MULTI_LAT=4 is in EXEC -> next cycle all outputs 0, state IDLE, no rsp_valid ever appears for that op.
- Single A request: a_op=3, a_x=8'h12, a_y=8'h34, MULTI_MASK=0 -> a_ready high 1 cycle; alu_sel=8'b0000_1000 for 1 cycle; rsp_valid 2 cycles after accept with rsp_id=0 and rsp_data equal to the modeled ALU result.
- Multi-cycle op: MULTI_MASK=8'h80, MULTI_LAT=5, b_op=7 -> alu_sel=8'h80 for exactly 5 cycles; rsp_valid 6 cycles after accept; rsp_id=1.
- Both ports valid continuously, 6 ops -> grant order A,B,A,B,A,B; with ALU_ARB_FIXED_PRIO_EN defined -> A x6, B never granted.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_data/rsp_id stable; busy=1; a_ready/b_ready stay 0; one bubble cycle after the handshake before the next ready.
- Valid withdrawn: a_valid pulses for 1 cycle while busy -> never captured; no response with rsp_id=0.
